fma_operand_loader: RTL and testbench
=====================================

FMA_OPERAND_LOADER -- requirements
Module: fma_operand_loader

Interface
REQ-001 Parameter WIDTH, default 32, is the floating-point operand word width in bits.
REQ-002 Parameter NPAIR, default 9, is the number of A/B product pairs per job (fixed at 9 for fpfma_pipeline).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  loader accepts a word this cycle; transfer occurs when in_valid && in_ready.
REQ-007 in_data  input  WIDTH  operand word, ordered A1..A9, B1..B9, C within a job.
REQ-008 in_last  input  1  marks the final word (C) of a job.
REQ-009 in_rnd  input  2  rounding mode; sampled only with word 0 of a job.
REQ-010 a_vec  output  NPAIR*WIDTH  A1 in bits [WIDTH-1:0], A9 in the top slot.
REQ-011 b_vec  output  NPAIR*WIDTH  B1..B9, same packing as a_vec.
REQ-012 c_out  output  WIDTH  addend C.
REQ-013 rnd_out  output  2  rounding mode of the presented job.
REQ-014 out_valid  output  1  complete job presented on a_vec/b_vec/c_out/rnd_out.
REQ-015 out_ready  input  1  downstream consumes the job when out_valid && out_ready.
REQ-016 frame_err  output  1  one-cycle pulse on a framing error.

Function
REQ-017 The loader SHALL hold a word counter wcnt (0..2*NPAIR), a shadow register bank (18 A/B words, C, rnd) and an output register bank driving the output ports.
REQ-018 States SHALL be FILL (collecting words; in_ready=1) and HOLD (shadow complete, output slot busy; in_ready=0).
REQ-019 In FILL each accepted word SHALL be written to the shadow slot given by wcnt, and wcnt SHALL increment by 1.
REQ-020 in_rnd SHALL be captured into shadow rnd only on acceptance of the word at wcnt=0.
REQ-021 A word accepted at wcnt=18 with in_last=1 completes the job; wcnt SHALL return to 0.
REQ-022 On completion, if out_valid=0 or (out_valid && out_ready) in that same cycle, the job SHALL be copied to the output bank at that edge (C taken directly from in_data), out_valid=1 next cycle, state stays FILL.
REQ-023 Otherwise on completion the state SHALL become HOLD; in HOLD the shadow job SHALL move to the output bank on the first edge where out_valid && out_ready, then state SHALL return to FILL.
REQ-024 Latency: last word accepted at edge N -> out_valid=1 after edge N when the slot is free; sustained throughput one word per cycle with no bubbles while downstream drains each job within 19 cycles.
REQ-025 When out_valid && out_ready and no new job is loaded at that edge, out_valid SHALL fall to 0 next cycle.
REQ-026 Output bank contents SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 Framing error: in_last=1 accepted at wcnt<18, or in_last=0 accepted at wcnt=18, SHALL discard the partial job, reset wcnt to 0, pulse frame_err for exactly one cycle, and leave the output bank untouched.
REQ-028 Words SHALL be treated as opaque bit patterns; no FP checking, conversion or reordering.
REQ-029 in_ready SHALL depend only on registered state (no combinational path from out_ready to in_ready).

Reset
REQ-030 While rst=1 at an edge: wcnt=0, state=FILL, out_valid=0, frame_err=0, all output and shadow registers zero; in_ready=0 during the rst cycle.
REQ-031 Reset mid-job or in HOLD SHALL discard all partial and pending jobs; first word after reset is treated as A1.

Verification
REQ-032 Single job: words 0x3F800000 (A1..A9), 0x40000000 (B1..B9), C=0x3F000000, in_last on word 19, in_rnd=2'b01, out_ready=1 -> out_valid one cycle after word 19, all a_vec slots 0x3F800000, c_out=0x3F000000, rnd_out=01.
REQ-033 Back-to-back jobs, out_ready=0 until word 19 of job 2 -> job 1 held stable, state HOLD, in_ready=0; raise out_ready -> job 2 presented next cycle, in_ready=1.
REQ-034 Early in_last on word 5 -> frame_err pulses one cycle, out_valid unchanged, next 19-word job loads correctly.
REQ-035 Missing in_last on word 19 -> frame_err pulse, no job emitted.
REQ-036 Simultaneous completion and drain (out_valid=1, out_ready=1 at job 2's last word) -> out_valid stays 1, job 2 data appears next cycle, no lost cycle.
REQ-037 rst asserted at wcnt=10 -> out_valid=0, next 19 words form a clean job with A1 = first word after reset.

Source files
------------

// File: rtl/fma_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fma_operand_loader
//  Description : Collects A1..A9, B1..B9, C operand words into a shadow bank
//                and hands complete jobs to a double-buffered output bank.
//  Revision    : 1.0  initial release
// ============================================================================
module fma_operand_loader #(
    parameter int WIDTH = 32,
    parameter int NPAIR = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    input  logic [1:0]             in_rnd,
    output logic [NPAIR*WIDTH-1:0] a_vec,
    output logic [NPAIR*WIDTH-1:0] b_vec,
    output logic [WIDTH-1:0]       c_out,
    output logic [1:0]             rnd_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_err
);

    localparam int                 c_cnt_w    = $clog2(2*NPAIR+1);
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(2*NPAIR);
    localparam logic [0:0]         c_st_fill  = 1'b0;
    localparam logic [0:0]         c_st_hold  = 1'b1;

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [c_cnt_w-1:0]     r_wcnt;
    logic [WIDTH-1:0]       r_sh_a [NPAIR];
    logic [WIDTH-1:0]       r_sh_b [NPAIR];
    logic [WIDTH-1:0]       r_sh_c;
    logic [1:0]             r_sh_rnd;
    logic [NPAIR*WIDTH-1:0] w_sh_a_flat;
    logic [NPAIR*WIDTH-1:0] w_sh_b_flat;
    logic [NPAIR*WIDTH-1:0] r_a_vec;
    logic [NPAIR*WIDTH-1:0] r_b_vec;
    logic [WIDTH-1:0]       r_c;
    logic [1:0]             r_rnd;
    logic                   r_out_valid;
    logic                   r_frame_err;

    logic w_accept, w_at_last, w_complete, w_frame_err, w_word_wr;
    logic w_slot_free, w_load_direct, w_load_shadow;

    // Ready is derived from registered state only, so downstream stalls never
    // ripple combinationally back to the upstream handshake.
    assign in_ready      = (r_state == c_st_fill) && !rst;
    assign w_accept      = in_valid && in_ready;
    assign w_at_last     = (r_wcnt == c_last_idx);
    assign w_complete    = w_accept && w_at_last && in_last;
    assign w_frame_err   = w_accept && (in_last != w_at_last);
    assign w_word_wr     = w_accept && !in_last && !w_at_last;
    assign w_slot_free   = !r_out_valid || out_ready;
    assign w_load_direct = w_complete && w_slot_free;
    assign w_load_shadow = (r_state == c_st_hold) && out_ready;

    for (genvar gi = 0; gi < NPAIR; gi++) begin : g_pack
        assign w_sh_a_flat[gi*WIDTH +: WIDTH] = r_sh_a[gi];
        assign w_sh_b_flat[gi*WIDTH +: WIDTH] = r_sh_b[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_fill;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_fill: if (w_complete && !w_slot_free) w_state_nxt = c_st_hold;
            c_st_hold: if (out_ready)                  w_state_nxt = c_st_fill;
            default:                                   w_state_nxt = c_st_fill;
        endcase
    end

    // Shadow bank: word counter and per-slot capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt   <= '0;
            r_sh_c   <= '0;
            r_sh_rnd <= '0;
            for (int i = 0; i < NPAIR; i++) begin
                r_sh_a[i] <= '0;
                r_sh_b[i] <= '0;
            end
        end else begin
            if (w_accept)
                r_wcnt <= (w_complete || w_frame_err) ? '0 : r_wcnt + 1'b1;
            if (w_word_wr && r_wcnt == '0)
                r_sh_rnd <= in_rnd;
            for (int i = 0; i < NPAIR; i++) begin
                if (w_word_wr && r_wcnt == c_cnt_w'(i))
                    r_sh_a[i] <= in_data;
                if (w_word_wr && r_wcnt == c_cnt_w'(i + NPAIR))
                    r_sh_b[i] <= in_data;
            end
            if (w_complete && !w_slot_free)
                r_sh_c <= in_data;
        end
    end

    // Output bank: loaded either straight from the final word or from a
    // parked shadow job once the presented job drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_vec     <= '0;
            r_b_vec     <= '0;
            r_c         <= '0;
            r_rnd       <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            if (w_load_shadow) begin
                r_a_vec     <= w_sh_a_flat;
                r_b_vec     <= w_sh_b_flat;
                r_c         <= r_sh_c;
                r_rnd       <= r_sh_rnd;
                r_out_valid <= 1'b1;
            end else if (w_load_direct) begin
                r_a_vec     <= w_sh_a_flat;
                r_b_vec     <= w_sh_b_flat;
                r_c         <= in_data;
                r_rnd       <= r_sh_rnd;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign a_vec     = r_a_vec;
    assign b_vec     = r_b_vec;
    assign c_out     = r_c;
    assign rnd_out   = r_rnd;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fma_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fma_operand_loader
//  Description : Randomized self-checking bench against a job-level queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fma_operand_loader;

    localparam int WIDTH = 32;
    localparam int NPAIR = 9;
    localparam int NW    = 2*NPAIR;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data = '0;
    logic                   in_last = 1'b0;
    logic [1:0]             in_rnd = '0;
    logic [NPAIR*WIDTH-1:0] a_vec;
    logic [NPAIR*WIDTH-1:0] b_vec;
    logic [WIDTH-1:0]       c_out;
    logic [1:0]             rnd_out;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   frame_err;

    fma_operand_loader #(.WIDTH(WIDTH), .NPAIR(NPAIR)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_rnd    (in_rnd),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .c_out     (c_out),
        .rnd_out   (rnd_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPAIR*WIDTH-1:0] a;
        logic [NPAIR*WIDTH-1:0] b;
        logic [WIDTH-1:0]       c;
        logic [1:0]             rnd;
    } job_t;

    // Model: completed jobs awaiting consumption (front = presented job)
    job_t             exp_q[$];
    logic [WIDTH-1:0] cur_q[$];
    logic [1:0]       cur_rnd;
    bit               pend_ferr;
    int               n_tests;
    int               n_fail;

    task automatic check_eq(input string tag, input logic [NPAIR*WIDTH-1:0] obs,
                            input logic [NPAIR*WIDTH-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_accept();
        job_t j;
        int   n = cur_q.size();
        if (in_last) begin
            if (n == NW) begin
                for (int i = 0; i < NPAIR; i++) begin
                    j.a[i*WIDTH +: WIDTH] = cur_q[i];
                    j.b[i*WIDTH +: WIDTH] = cur_q[NPAIR+i];
                end
                j.c   = in_data;
                j.rnd = cur_rnd;
                exp_q.push_back(j);
            end else begin
                pend_ferr = 1'b1;
            end
            cur_q.delete();
        end else if (n == NW) begin
            pend_ferr = 1'b1;
            cur_q.delete();
        end else begin
            if (n == 0) cur_rnd = in_rnd;
            cur_q.push_back(in_data);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, advance model.
    task automatic step(input bit do_rst, input bit directed, input int valid_pct,
                        input int ready_pct, input int err_div);
        int  n;
        bit  m_in_rdy;
        bit  m_out_vld;
        @(negedge clk);
        check_eq("out_valid", out_valid, exp_q.size() > 0);
        check_eq("in_ready", in_ready, !rst && exp_q.size() < 2);
        check_eq("frame_err", frame_err, pend_ferr);
        pend_ferr = 1'b0;
        if (exp_q.size() > 0) begin
            check_eq("a_vec", a_vec, exp_q[0].a);
            check_eq("b_vec", b_vec, exp_q[0].b);
            check_eq("c_out", c_out, exp_q[0].c);
            check_eq("rnd_out", rnd_out, exp_q[0].rnd);
        end

        n   = cur_q.size();
        rst = do_rst;
        if (directed) begin
            in_valid  = 1'b1;
            in_data   = (n < NPAIR) ? 32'h3F80_0000 : (n < NW) ? 32'h4000_0000 : 32'h3F00_0000;
            in_last   = (n == NW);
            in_rnd    = 2'b01;
            out_ready = 1'b1;
        end else begin
            in_valid  = ($urandom_range(99) < valid_pct);
            in_data   = $urandom;
            in_rnd    = 2'($urandom_range(3));
            in_last   = (n == NW) ^ (err_div > 0 && $urandom_range(err_div-1) == 0);
            out_ready = ($urandom_range(99) < ready_pct);
        end
        #1;

        m_out_vld = exp_q.size() > 0;
        m_in_rdy  = !rst && exp_q.size() < 2;
        if (rst) begin
            exp_q.delete();
            cur_q.delete();
            pend_ferr = 1'b0;
        end else begin
            if (m_out_vld && out_ready) void'(exp_q.pop_front());
            if (in_valid && m_in_rdy) model_accept();
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        pend_ferr = 1'b0;
        cur_rnd   = '0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_eq("rst_a_vec", a_vec, '0);
        check_eq("rst_b_vec", b_vec, '0);
        check_eq("rst_c_out", c_out, '0);
        check_eq("rst_rnd", rnd_out, '0);

        // Known-value job with a free output slot
        repeat (NW + 1) step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 100, 0);

        // Random phases: free flow, heavy backpressure, tight drain, framing errors
        for (int p = 0; p < 5; p++) begin
            int vp, rp, ed;
            case (p)
                0:       begin vp = 90;  rp = 90;  ed = 0;  end
                1:       begin vp = 100; rp = 8;   ed = 0;  end
                2:       begin vp = 100; rp = 100; ed = 0;  end
                3:       begin vp = 80;  rp = 50;  ed = 30; end
                default: begin vp = 100; rp = 30;  ed = 20; end
            endcase
            for (int c = 0; c < 800; c++)
                step($urandom_range(399) == 0, 0, vp, rp, ed);
        end

        // Reset in the middle of a partial job, then a clean job
        repeat (10) step(0, 0, 100, 100, 0);
        step(1, 0, 0, 100, 0);
        repeat (NW + 1) step(0, 1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 100, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
